// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered 8N1 UART transmitter.
// Bytes enter a FIFO through a valid/ready handshake. A baud-rate FSM
// serialises them LSB first, back-to-back, onto a registered txd pin.
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int CLK_PER_BIT     = 868,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     txd,
  output logic                     busy,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int DEPTH  = 1 << FIFO_DEPTH_LOG2;
  localparam int BAUD_W = $clog2(CLK_PER_BIT);
  localparam logic [BAUD_W-1:0]          BAUD_LAST  = BAUD_W'(CLK_PER_BIT - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t                     state_q, state_d;
  logic [BAUD_W-1:0]          baud_q, baud_d;
  logic [2:0]                 bitIdx_q, bitIdx_d;
  logic [7:0]                 data_q, data_d;
  logic                       txd_q, txd_d;
  logic [FIFO_DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
  logic [FIFO_DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]                 mem_q [DEPTH];

  logic push;
  logic pop;
  logic fifoEmpty;
  logic baudLast;

  assign fifoEmpty  = (count_q == '0);
  assign in_ready   = (count_q != FULL_COUNT);
  assign push       = in_valid && in_ready;
  assign baudLast   = (baud_q == BAUD_LAST);
  assign busy       = (state_q != IDLE) || !fifoEmpty;
  assign fifo_count = count_q;
  assign txd        = txd_q;

  // FIFO storage: contents need no reset, the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= in_data;
    end
  end

  // FIFO bookkeeping: pointers wrap naturally, count carries an extra bit for full.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push) begin
      wrPtr_d = wrPtr_q + FIFO_DEPTH_LOG2'(1);
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + FIFO_DEPTH_LOG2'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (FIFO_DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (FIFO_DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencing: pops happen only from IDLE or the final STOP cycle.
  always_comb begin
    state_d  = state_q;
    bitIdx_d = bitIdx_q;
    data_d   = data_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifoEmpty) begin
          pop     = 1'b1;
          data_d  = mem_q[rdPtr_q];
          state_d = START;
        end
      end
      START: begin
        if (baudLast) begin
          state_d  = DATA;
          bitIdx_d = 3'd0;
        end
      end
      DATA: begin
        if (baudLast) begin
          if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baudLast) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (baudLast) begin
          if (!fifoEmpty) begin
            pop     = 1'b1;
            data_d  = mem_q[rdPtr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Baud timing and the registered pin value, derived from the upcoming state.
  always_comb begin
    baud_d = baud_q + BAUD_W'(1);
    if ((state_d != state_q) || baudLast || (state_q == IDLE)) begin
      baud_d = '0;
    end
    case (state_d)
      IDLE:    txd_d = 1'b1;
      START:   txd_d = 1'b0;
      DATA:    txd_d = data_d[bitIdx_d];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_d = ^data_d;
`endif
      STOP:    txd_d = 1'b1;
      default: txd_d = 1'b1;
    endcase
  end

  // State registers; reset aborts any frame and flushes the FIFO.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bitIdx_q <= 3'd0;
      data_q   <= 8'd0;
      txd_q    <= 1'b1;
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitIdx_q <= bitIdx_d;
      data_q   <= data_d;
      txd_q    <= txd_d;
      wrPtr_q  <= wrPtr_d;
      rdPtr_q  <= rdPtr_d;
      count_q  <= count_d;
    end
  end

endmodule
